// File: rtl/risc32i_pkg.sv
// rtl/risc32i_pkg.sv - shared core types and constants
package risc32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - ROM and decode-side handshake bundle of the fetch unit
interface instr_fetch_unit_if #(
  parameter int ROM_ADDR_W = 10
);
  import risc32i_pkg::*;

  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [XLEN-1:0]       rom_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [XLEN-1:0]       instr;
  logic [XLEN-1:0]       instr_pc;

  modport master (
    output rom_addr,
    input  rom_data,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// rtl/instr_fetch_unit_fifo.sv - prefetch FIFO of {pc, instr} entries
module fetch_fifo
  import risc32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC sequencing, ROM addressing and prefetch buffering
module instr_fetch_unit
  import risc32i_pkg::*;
#(
  parameter int              ROM_ADDR_W = 10,
  parameter int              DEPTH      = 2,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fetch_en_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  instr_fetch_unit_if.master  bus
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] last_pc_q;
  logic            push, pop, full, empty;
  fetch_entry_t    head, wr_entry;

  assign pop      = bus.instr_valid & bus.instr_ready;
  assign push     = fetch_en_i & ~redirect_i & (~full | pop);
  assign wr_entry = '{pc: fetch_pc_q, instr: bus.rom_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop & ~redirect_i),
    .flush_i (redirect_i),
    .data_i  (wr_entry),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i)  fetch_pc_d = redirect_pc_i & ~32'h3;
    else if (push)   fetch_pc_d = fetch_pc_q + 32'd4;
  end

  // last_pc_q lets INSTR_PC keep showing the previous head once the FIFO runs dry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      last_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      last_pc_q  <= bus.instr_pc;
    end
  end

  assign bus.rom_addr    = fetch_pc_q[ROM_ADDR_W+1:2];
  assign bus.instr_valid = ~empty;
  assign bus.instr       = empty ? INSTR_NOP : head.instr;
  assign bus.instr_pc    = empty ? last_pc_q : head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import risc32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ROM_ADDR_W(10)) bus  ();
  instr_fetch_unit_if #(.ROM_ADDR_W(10)) bus2 ();

  // ROM[i] = i * 0x11
  assign bus.rom_data  = 32'(bus.rom_addr) * 32'h11;
  assign bus2.rom_data = 32'(bus2.rom_addr) * 32'h11;

  instr_fetch_unit #(.ROM_ADDR_W(10), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_en_i    (fetch_en),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .bus           (bus)
  );

  instr_fetch_unit #(.ROM_ADDR_W(10), .DEPTH(2), .RESET_PC(32'hFFC)) dut_wrap (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_en_i    (fetch_en),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .bus           (bus2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = '0;
    bus.instr_ready = 1'b1;
    bus2.instr_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'h00000013);
    check("rst_pc", bus.instr_pc, 32'd0);
    check("rst_addr", 32'(bus.rom_addr), 32'd0);
    check("wrap_rst_addr", 32'(bus2.rom_addr), 32'd1023);

    // streaming at one instruction per cycle
    rst = 1'b0;
    tick();
    check("wrap_pc0", bus2.instr_pc, 32'hFFC);
    check("wrap_instr0", bus2.instr, 32'd1023 * 32'h11);
    check("wrap_addr1", 32'(bus2.rom_addr), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("stream_valid", 32'(bus.instr_valid), 32'd1);
      check("stream_instr", bus.instr, 32'(i) * 32'h11);
      check("stream_pc", bus.instr_pc, 32'(i) * 32'd4);
      if (i == 1) begin
        check("wrap_pc1", bus2.instr_pc, 32'h1000);
        check("wrap_instr1", bus2.instr, 32'h0);
      end
      tick();
    end

    // backpressure from reset: fill, hold, release without gaps
    rst = 1'b1; bus.instr_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(bus.instr_valid), 32'd1);
      check("hold_instr", bus.instr, 32'h0);
      check("hold_pc", bus.instr_pc, 32'h0);
    end
    check("hold_addr", 32'(bus.rom_addr), 32'd2);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("release_pc", bus.instr_pc, 32'(i) * 32'd4);
      check("release_instr", bus.instr, 32'(i) * 32'h11);
      tick();
    end

    // redirect while full; target low bits dropped
    bus.instr_ready = 1'b0;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0; bus.instr_ready = 1'b1;
    check("redir_valid0", 32'(bus.instr_valid), 32'd0);
    check("redir_addr", 32'(bus.rom_addr), 32'h40);
    tick();
    check("redir_valid1", 32'(bus.instr_valid), 32'd1);
    check("redir_pc", bus.instr_pc, 32'h100);
    check("redir_instr", bus.instr, 32'h440);
    tick();
    check("redir_pc1", bus.instr_pc, 32'h104);
    check("redir_instr1", bus.instr, 32'h451);
    tick();
    check("redir_pc2", bus.instr_pc, 32'h108);

    // fetch disabled: drain, then hold address
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(bus.instr_valid), 32'd0);
      check("stall_instr", bus.instr, 32'h00000013);
      check("stall_pc", bus.instr_pc, 32'h108);
      check("stall_addr", 32'(bus.rom_addr), 32'h43);
    end
    fetch_en = 1'b1;
    tick();
    check("resume_valid", 32'(bus.instr_valid), 32'd1);
    check("resume_pc", bus.instr_pc, 32'h10C);
    check("resume_instr", bus.instr, 32'h473);

    // reset beats a simultaneous redirect
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    check("rr_valid", 32'(bus.instr_valid), 32'd0);
    check("rr_instr", bus.instr, 32'h00000013);
    check("rr_pc", bus.instr_pc, 32'h0);
    check("rr_addr", 32'(bus.rom_addr), 32'd0);
    rst = 1'b0; redirect = 1'b0;
    tick();
    check("rr_first_valid", 32'(bus.instr_valid), 32'd1);
    check("rr_first_pc", bus.instr_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
